// File: rtl/serial_word_deser.sv
// serial_word_deser
//   Collects serial bits into a WIDTH-bit word and presents it on a
//   valid/ready output with a single-entry holding register.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   sin        : serial data bit
//   sin_vld    : qualifies sin (and sof) on this edge
//   sof        : start of word; aborts any partial word (sets frame_err)
//   dir        : 0 = MSB-first (shift left), 1 = LSB-first (shift right);
//                latched on the first bit of each word
//   clear      : synchronous flush of all state and sticky flags
//   pout       : assembled word
//   pout_vld   : pout holds an unaccepted word
//   pout_rdy   : consumer accepts pout
//   busy       : partial word in progress
//   ovf        : sticky, a completed word was dropped
//   frame_err  : sticky, a partial word was aborted by sof
module serial_word_deser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] pout,
    output logic             pout_vld,
    input  logic             pout_rdy,
    output logic             busy,
    output logic             ovf,
    output logic             frame_err
);

    // count never reaches WIDTH: the last bit returns it straight to 0
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [WIDTH-1:0]  sreg, sreg_n;
    logic              dir_lat, dir_lat_n;
    logic [WIDTH-1:0]  pout_n;
    logic              pout_vld_n;
    logic              ovf_n;
    logic              frame_err_n;

    // per-bit working values
    logic              starting;
    logic              use_dir;
    logic [WIDTH-1:0]  base;
    logic [CW-1:0]     cnt_base;
    logic [WIDTH-1:0]  shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            dir_lat   <= 1'b0;
            pout      <= '0;
            pout_vld  <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            sreg      <= sreg_n;
            dir_lat   <= dir_lat_n;
            pout      <= pout_n;
            pout_vld  <= pout_vld_n;
            ovf       <= ovf_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        sreg_n      = sreg;
        dir_lat_n   = dir_lat;
        pout_n      = pout;
        pout_vld_n  = pout_vld;
        ovf_n       = ovf;
        frame_err_n = frame_err;

        // a new word starts on the first bit in IDLE or on sof in RECV;
        // either way the bit is treated as bit 0 with a freshly latched dir
        starting = (state == IDLE) || sof;
        use_dir  = starting ? dir : dir_lat;
        base     = starting ? '0 : sreg;
        cnt_base = starting ? '0 : count;
        shifted  = use_dir ? {sin, base[WIDTH-1:1]} : {base[WIDTH-2:0], sin};

        if (clear) begin
            state_n     = IDLE;
            count_n     = '0;
            sreg_n      = '0;
            dir_lat_n   = 1'b0;
            pout_n      = '0;
            pout_vld_n  = 1'b0;
            ovf_n       = 1'b0;
            frame_err_n = 1'b0;
        end else begin
            if (pout_vld && pout_rdy) begin
                pout_vld_n = 1'b0;
            end
            if (sin_vld) begin
                if (state == RECV && sof) begin
                    frame_err_n = 1'b1;
                end
                if (cnt_base == CW'(WIDTH - 1)) begin
                    state_n   = IDLE;
                    count_n   = '0;
                    sreg_n    = '0;
                    dir_lat_n = use_dir;
                    // holding register is free if empty or emptied this edge
                    if (!pout_vld || pout_rdy) begin
                        pout_n     = shifted;
                        pout_vld_n = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else begin
                    state_n   = RECV;
                    count_n   = cnt_base + 1'b1;
                    sreg_n    = shifted;
                    dir_lat_n = use_dir;
                end
            end
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_word_deser.sv
// tb_serial_word_deser
//   Directed bench for serial_word_deser (WIDTH=16). Stimulus pushes each
//   word that must reach the consumer into a queue; a monitor pops and
//   compares on every accepted output. Flag/state checks are inline.
module tb_serial_word_deser;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0;
    logic         sin_vld = 1'b0;
    logic         sof = 1'b0;
    logic         dir = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] pout;
    logic         pout_vld;
    logic         pout_rdy = 1'b0;
    logic         busy;
    logic         ovf;
    logic         frame_err;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    serial_word_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_vld   (sin_vld),
        .sof       (sof),
        .dir       (dir),
        .clear     (clear),
        .pout      (pout),
        .pout_vld  (pout_vld),
        .pout_rdy  (pout_rdy),
        .busy      (busy),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // monitor: an accepted word is one with vld&rdy seen at the negedge
    always @(negedge clk) begin
        if (rst_n && !clear && pout_vld && pout_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL accept: unexpected word got %h required none", pout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (pout !== e) begin
                    n_err++;
                    $display("FAIL accept: got %h required %h", pout, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin = b; sof = s; sin_vld = 1'b1;
        tick();
        sin_vld = 1'b0; sof = 1'b0;
    endtask

    // d: bit order; gaps: random idle cycles between bits;
    // flip: toggle dir after bit 0; rdy_last: raise pout_rdy with bit 15
    task automatic send_word(input logic [W-1:0] w, input logic d, input bit gaps,
                             input bit flip, input bit rdy_last);
        dir = d;
        for (int unsigned i = 0; i < W; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (rdy_last && i == W - 1) pout_rdy = 1'b1;
            send_bit(d ? w[i] : w[W-1-i], 1'b0);
            if (flip) dir = ~dir;
            chk("busy", {31'b0, busy}, {31'b0, (i < W - 1)});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pout"}, {16'b0, pout}, 32'h0);
        chk({tag, "_vld"}, {31'b0, pout_vld}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_ovf"}, {31'b0, ovf}, 32'h0);
        chk({tag, "_ferr"}, {31'b0, frame_err}, 32'h0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #2;
        chk_zero("reset");
        #20;
        rst_n = 1'b1;
        tick();

        // MSB-first word, consumer always ready
        pout_rdy = 1'b1;
        exp_q.push_back(16'hA5C3);
        send_word(16'hA5C3, 1'b0, 0, 0, 0);
        chk("a5c3_vld", {31'b0, pout_vld}, 32'h1);
        chk("a5c3_pout", {16'b0, pout}, 32'h0000A5C3);
        tick();
        chk("a5c3_vld_drop", {31'b0, pout_vld}, 32'h0);

        // LSB-first with gaps and dir toggling mid-word
        exp_q.push_back(16'h8001);
        send_word(16'h8001, 1'b1, 1, 1, 0);
        chk("8001_pout", {16'b0, pout}, 32'h00008001);
        tick();

        // overflow: second word dropped while first is unaccepted
        pout_rdy = 1'b0;
        exp_q.push_back(16'h1234);
        send_word(16'h1234, 1'b0, 0, 0, 0);
        send_word(16'hFFFF, 1'b0, 0, 0, 0);
        chk("ovf_pout", {16'b0, pout}, 32'h00001234);
        chk("ovf_flag", {31'b0, ovf}, 32'h1);
        pout_rdy = 1'b1;
        tick();
        pout_rdy = 1'b0;
        chk("ovf_vld_after", {31'b0, pout_vld}, 32'h0);
        tick();
        chk("ovf_sticky", {31'b0, ovf}, 32'h1);
        do_clear();
        chk("ovf_cleared", {31'b0, ovf}, 32'h0);

        // completion coinciding with a transfer replaces the word, no ovf
        exp_q.push_back(16'h1111);
        send_word(16'h1111, 1'b0, 0, 0, 0);
        exp_q.push_back(16'h2222);
        send_word(16'h2222, 1'b0, 0, 0, 1);
        chk("swap_pout", {16'b0, pout}, 32'h00002222);
        chk("swap_vld", {31'b0, pout_vld}, 32'h1);
        chk("swap_ovf", {31'b0, ovf}, 32'h0);
        tick();
        chk("swap_vld_after", {31'b0, pout_vld}, 32'h0);

        // sof aborts a partial word and restarts with its own bit
        dir = 1'b0;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        chk("ferr_before", {31'b0, frame_err}, 32'h0);
        exp_q.push_back(16'hC000);
        send_bit(1'b1, 1'b1);
        chk("ferr_set", {31'b0, frame_err}, 32'h1);
        chk("ferr_busy", {31'b0, busy}, 32'h1);
        send_bit(1'b1, 1'b0);
        for (int unsigned i = 0; i < 14; i++) send_bit(1'b0, 1'b0);
        chk("c000_pout", {16'b0, pout}, 32'h0000C000);
        chk("ferr_sticky", {31'b0, frame_err}, 32'h1);
        tick();
        do_clear();

        // reset mid-word, then clear mid-word
        for (int unsigned i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(16'h0F0F);
        send_word(16'h0F0F, 1'b0, 0, 0, 0);
        tick();
        for (int unsigned i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        clear = 1'b1; sin = 1'b1; sin_vld = 1'b1;
        tick();
        clear = 1'b0; sin_vld = 1'b0;
        chk_zero("clr_mid");
        exp_q.push_back(16'h5A3C);
        send_word(16'h5A3C, 1'b0, 0, 0, 0);
        chk("5a3c_pout", {16'b0, pout}, 32'h00005A3C);
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
